// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO drain arbiter.
// The optional burst drain is enabled by defining DRAIN_BURST_EN.
package fifo_arb_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting index after ptr, wrapping.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = ch_idx_w(DEF_NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              gnt_valid,
    output logic [CH_W-1:0]   gnt_idx
);

    // Scan from the farthest offset down so the nearest request after ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int ofs = NUM_CH; ofs >= 1; ofs--) begin
            idx = (int'(ptr) + ofs) % NUM_CH;
            if (req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_CH FIFOs round-robin into a single valid/ready word stream.
// Define DRAIN_BURST_EN to drain up to BURST_LEN words per grant.
module fifo_drain_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_CH    = DEF_NUM_CH,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  RD_LAT    = 1,
    parameter int  BURST_LEN = 4,
    localparam int CH_W      = ch_idx_w(NUM_CH)
) (
    input  logic                     CLK,
    input  logic                     AINIT,
    input  logic                     ENABLE,
    input  logic [NUM_CH-1:0]        CH_EMPTY,
    input  logic [NUM_CH*DATA_W-1:0] CH_DOUT,
    output logic [NUM_CH-1:0]        CH_RD_EN,
    output logic [DATA_W-1:0]        M_DATA,
    output logic [CH_W-1:0]          M_CH,
    output logic                     M_VALID,
    input  logic                     M_READY,
    output logic                     BUSY,
    output arb_state_t               DBG_STATE
);

    // Output handshake: a word transfers on a rising CLK edge where M_VALID and
    // M_READY are both 1; M_VALID never drops and M_DATA/M_CH never change until then.

    if (RD_LAT < 1 || RD_LAT > 3 || BURST_LEN < 1) begin : g_bad_param
        $error("fifo_drain_arbiter: RD_LAT must be 1..3 and BURST_LEN at least 1");
    end

    arb_state_t      state, state_d;
    logic [CH_W-1:0] ptr;
    logic [1:0]      wait_cnt;
    logic            gnt_valid;
    logic [CH_W-1:0] gnt_idx;
    logic            grant, last_wait, handshake, burst_go;

    rr_priority_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .req       (~CH_EMPTY),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

`ifdef DRAIN_BURST_EN
    localparam int BC_W = ch_idx_w(BURST_LEN + 1);
    logic [BC_W-1:0] burst_cnt;

    // Stay on the granted channel while it has data and the burst has room.
    assign burst_go = !CH_EMPTY[ptr] && (burst_cnt < BC_W'(BURST_LEN - 1));

    always_ff @(posedge CLK) begin
        if (AINIT || grant) begin
            burst_cnt <= '0;
        end else if (handshake) begin
            burst_cnt <= burst_go ? burst_cnt + 1'b1 : '0;
        end
    end
`else
    assign burst_go = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        grant     = 1'b0;
        last_wait = 1'b0;
        handshake = 1'b0;
        CH_RD_EN  = '0;
        case (state)
            IDLE: begin
                if (ENABLE && gnt_valid) begin
                    grant   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                CH_RD_EN[ptr] = 1'b1;
                state_d       = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 2'(RD_LAT - 1)) begin
                    last_wait = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (M_READY) begin
                    handshake = 1'b1;
                    state_d   = burst_go ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (AINIT) begin
            state    <= IDLE;
            ptr      <= CH_W'(NUM_CH - 1);
            wait_cnt <= '0;
            M_DATA   <= '0;
            M_CH     <= '0;
        end else begin
            state <= state_d;
            if (grant) begin
                ptr <= gnt_idx;
            end
            if (state == READ) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end
            // CH_DOUT is only guaranteed valid on the final WAIT cycle.
            if (last_wait) begin
                M_DATA <= CH_DOUT[ptr*DATA_W +: DATA_W];
                M_CH   <= ptr;
            end
        end
    end

    assign M_VALID   = (state == HOLD);
    assign BUSY      = (state != IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Self-checking bench for fifo_drain_arbiter: FIFO environment model, transaction-level reference, directed and random steps.
module tb_fifo_drain_arbiter;
    import fifo_arb_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 16;
    localparam int RD_LAT    = 1;
    localparam int BURST_LEN = 4;
    localparam int DEPTH     = 256;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     ainit, enable, m_ready;
    logic [NUM_CH-1:0]        ch_empty;
    logic [NUM_CH*DATA_W-1:0] ch_dout;
    logic [NUM_CH-1:0]        ch_rd_en;
    logic [DATA_W-1:0]        m_data;
    logic [1:0]               m_ch;
    logic                     m_valid, busy;
    arb_state_t               dbg_state;

    fifo_drain_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BURST_LEN(BURST_LEN)
    ) dut (
        .CLK(clk), .AINIT(ainit), .ENABLE(enable), .CH_EMPTY(ch_empty),
        .CH_DOUT(ch_dout), .CH_RD_EN(ch_rd_en), .M_DATA(m_data), .M_CH(m_ch),
        .M_VALID(m_valid), .M_READY(m_ready), .BUSY(busy), .DBG_STATE(dbg_state)
    );

    // ---------------- FIFO environment ----------------
    logic [DATA_W-1:0] fmem [NUM_CH][DEPTH];
    int fwr [NUM_CH];
    int frd [NUM_CH];

    // ---------------- reference model / scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        got_ch_q[$];
    logic [DATA_W-1:0] got_data_q[$];
    bit pend_rd, in_flight, prev_rd, chk_rst_vals, strobe_seen;
    int pend_ch, fl_ch, k, last_ch, burst_cnt, strobe_ch, handshakes, strobes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [DATA_W-1:0] w);
        fmem[c][fwr[c] % DEPTH] = w;
        fwr[c]++;
    endtask

    task automatic clear_fifos();
        for (int c = 0; c < NUM_CH; c++) frd[c] = fwr[c];
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend_rd      = 0;
        in_flight    = 0;
        prev_rd      = 0;
        k            = 0;
        last_ch      = NUM_CH - 1;
        burst_cnt    = 0;
        chk_rst_vals = 1;
    endtask

    // One cycle of the reference: what the arbiter must show now, and what it must do next.
    task automatic model_check();
        bit hs, found;
        int nxt, c;
        if (chk_rst_vals) begin
            chk("rst_m_data", m_data, 0);
            chk("rst_m_ch", m_ch, 0);
            chk("rst_state", dbg_state, IDLE);
            chk_rst_vals = 0;
        end
        chk("ch_rd_en", ch_rd_en, pend_rd ? 4'(1 << pend_ch) : 4'b0);
        chk("rd_gap", prev_rd && (|ch_rd_en), 0);
        if (pend_rd) begin
            in_flight = 1;
            fl_ch     = pend_ch;
            k         = 0;
            exp_q.push_back(fmem[fl_ch][frd[fl_ch] % DEPTH]);
        end
        chk("busy", busy, in_flight);
        chk("m_valid", m_valid, in_flight && (k >= RD_LAT + 1));
        hs = 0;
        if (in_flight && (k >= RD_LAT + 1)) begin
            chk("m_ch", m_ch, fl_ch);
            chk("m_data", m_data, exp_q[0]);
            if (m_ready) begin
                hs = 1;
                handshakes++;
                got_ch_q.push_back(m_ch);
                got_data_q.push_back(m_data);
                void'(exp_q.pop_front());
            end
        end
        pend_rd = 0;
        if (!in_flight) begin
            if (enable && ch_empty != '1) begin
                found = 0;
                nxt   = 0;
                for (int o = 1; o <= NUM_CH; o++) begin
                    c = (last_ch + o) % NUM_CH;
                    if (!found && !ch_empty[c]) begin
                        found = 1;
                        nxt   = c;
                    end
                end
                pend_rd   = 1;
                pend_ch   = nxt;
                last_ch   = nxt;
                burst_cnt = 0;
            end
        end else if (hs) begin
            in_flight = 0;
`ifdef DRAIN_BURST_EN
            if (!ch_empty[fl_ch] && burst_cnt < BURST_LEN - 1) begin
                pend_rd = 1;
                pend_ch = fl_ch;
                burst_cnt++;
            end else begin
                burst_cnt = 0;
            end
`endif
        end
        if (in_flight) k++;
        prev_rd = |ch_rd_en;
    endtask

    // Advance one clock: refresh empties, check at negedge, then let the FIFOs react.
    task automatic tick();
        for (int c = 0; c < NUM_CH; c++) ch_empty[c] = (fwr[c] == frd[c]);
        @(negedge clk);
        strobe_seen = |ch_rd_en;
        strobe_ch   = 0;
        for (int c = NUM_CH - 1; c >= 0; c--) if (ch_rd_en[c]) strobe_ch = c;
        if (strobe_seen) strobes++;
        if (!ainit) model_check();
        @(posedge clk);
        #1;
        if (ainit) model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            if (strobe_seen && strobe_ch == c && fwr[c] != frd[c]) begin
                ch_dout[c*DATA_W +: DATA_W] = fmem[c][frd[c] % DEPTH];
                frd[c]++;
            end else begin
                ch_dout[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        ainit = 1;
        repeat (2) tick();
        ainit = 0;
        clear_fifos();
        got_ch_q.delete();
        got_data_q.delete();
    endtask

    task automatic run_until_hs(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (handshakes < target && n < budget) begin
            tick();
            n++;
        end
        chk(tag, handshakes, target);
    endtask

    task automatic wait_strobe(input int budget, input string tag);
        int n;
        n = 0;
        strobe_seen = 0;
        while (!strobe_seen && n < budget) begin
            tick();
            n++;
        end
        chk(tag, strobe_seen, 1);
    endtask

    initial begin
        int h0, s0;
        ainit = 1; enable = 0; m_ready = 0; ch_empty = '1; ch_dout = '0;
        handshakes = 0; strobes = 0; strobe_seen = 0;
        for (int c = 0; c < NUM_CH; c++) begin fwr[c] = 0; frd[c] = 0; end
        model_reset();

        // All channels empty: no activity for 20 cycles.
        do_reset();
        enable = 1;
        repeat (20) tick();

        // Two channels, fixed words, delivered in round-robin order from channel 0.
        m_ready = 1;
        push(0, 16'hA5A5);
        push(2, 16'h3C3C);
        run_until_hs(handshakes + 2, 40, "two_ch_done");
        chk("two_ch_first_ch", got_ch_q[0], 0);
        chk("two_ch_first_data", got_data_q[0], 16'hA5A5);
        chk("two_ch_second_ch", got_ch_q[1], 2);
        chk("two_ch_second_data", got_data_q[1], 16'h3C3C);

        // All four busy: strict rotation 0,1,2,3,0.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int i = 0; i < 6; i++) push(c, DATA_W'($urandom));
        run_until_hs(handshakes + 5, 60, "rot_done");
        for (int i = 0; i < 5; i++) chk("rot_seq", got_ch_q[i], i % NUM_CH);

        // Back-pressure: M_READY low for 10 cycles while holding a word.
        m_ready = 0;
        wait_strobe(20, "bp_strobe");
        repeat (RD_LAT + 1) tick();
        s0 = strobes;
        repeat (10) tick();
        chk("bp_no_strobe", strobes, s0);
        chk("bp_valid_held", m_valid, 1);
        h0 = handshakes;
        m_ready = 1;
        run_until_hs(h0 + 2, 20, "bp_release");

        // ENABLE dropped during WAIT: word still delivered, then no new grant.
        wait_strobe(20, "en_strobe");
        enable = 0;
        h0 = handshakes;
        s0 = strobes;
        repeat (15) tick();
        chk("en_drop_delivered", handshakes, h0 + 1);
        chk("en_drop_no_grant", strobes, s0);
        enable = 1;
        run_until_hs(h0 + 2, 20, "en_resume");

        // Reset during WAIT: transfer abandoned, channel 0 wins next.
        push(0, 16'h1234);
        wait_strobe(20, "rst_strobe");
        ainit = 1;
        tick();
        ainit = 0;
        tick();
        chk("rst_wait_valid", m_valid, 0);
        h0 = handshakes;
        run_until_hs(h0 + 1, 20, "rst_regrant");
        chk("rst_regrant_ch", got_ch_q[got_ch_q.size()-1], 0);

`ifdef DRAIN_BURST_EN
        // Burst: four words from channel 1, then channel 3.
        do_reset();
        for (int i = 0; i < 20; i++) push(1, DATA_W'($urandom));
        push(3, 16'hC3C3);
        run_until_hs(handshakes + 5, 60, "burst_done");
        for (int i = 0; i < 4; i++) chk("burst_ch1", got_ch_q[i], 1);
        chk("burst_ch3", got_ch_q[4], 3);
        chk("burst_ch3_data", got_data_q[4], 16'hC3C3);
`endif

        // Random traffic, back-pressure, enable gaps and occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            enable  = ($urandom_range(0, 9) != 0);
            m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0) push($urandom_range(0, NUM_CH - 1), DATA_W'($urandom));
            ainit = ($urandom_range(0, 249) == 0);
            tick();
        end
        ainit = 0;
        enable = 1;
        m_ready = 1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
